// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage stall mask, multi-cycle EX hold and exception flush/redirect FSM.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int STAGES       = 6,
  parameter int PC_W         = 32,
  parameter int LEN_W        = 6,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_id,
  input  logic              stallreq_load,
  input  logic              stallreq_ex,
  input  logic              mc_start,
  input  logic [LEN_W-1:0]  mc_len,
  input  logic              excp_valid,
  input  logic [PC_W-1:0]   excp_pc,
  output logic [STAGES-1:0] stall,
  output logic              flush,
  output logic [PC_W-1:0]   new_pc,
  output logic [1:0]        ctrl_state,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MC_BUSY = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

  // Bits 0..k set: stalling stage k also freezes every stage upstream of it.
  function automatic logic [STAGES-1:0] stage_mask(input int k);
    logic [STAGES-1:0] m;
    m = {STAGES{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      if (i <= k) m[i] = 1'b1;
      else        m[i] = 1'b0;
    end
    return m;
  endfunction

  localparam logic [STAGES-1:0] ID_MASK = stage_mask(2);
  localparam logic [STAGES-1:0] EX_MASK = stage_mask(3);
  localparam logic [3:0]        FL_LOAD = 4'(FLUSH_CYCLES);

  state_t              state_r, state_s;
  logic [LEN_W-1:0]    mc_cnt_r, mc_cnt_s;
  logic [3:0]          fl_cnt_r, fl_cnt_s;
  logic                flush_r, flush_s;
  logic [PC_W-1:0]     new_pc_r, new_pc_s;
  logic [STAGES-1:0]   stall_s;
  logic                mc_len_ok_s;

  assign mc_len_ok_s = (mc_len != {LEN_W{1'b0}});

  // Stall mask from the current state, and next-state/counter computation.
  always_comb begin
    state_s  = state_r;
    mc_cnt_s = mc_cnt_r;
    fl_cnt_s = fl_cnt_r;
    flush_s  = flush_r;
    new_pc_s = new_pc_r;
    stall_s  = {STAGES{1'b0}};

    if (rst) begin
      stall_s = {STAGES{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (stallreq_ex || (mc_start && mc_len_ok_s)) stall_s = EX_MASK;
          else if (stallreq_load || stallreq_id)         stall_s = ID_MASK;
          else                                           stall_s = {STAGES{1'b0}};
        end
        ST_MC_BUSY: stall_s = EX_MASK;
        ST_FLUSH:   stall_s = {STAGES{1'b0}};
        default:    stall_s = {STAGES{1'b0}};
      endcase
    end

    // An exception overrides everything, including an in-flight multi-cycle op.
    if (excp_valid) begin
      state_s  = ST_FLUSH;
      flush_s  = 1'b1;
      new_pc_s = excp_pc;
      fl_cnt_s = FL_LOAD;
      mc_cnt_s = {LEN_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mc_start && (mc_len >= LEN_W'(2))) begin
            state_s  = ST_MC_BUSY;
            mc_cnt_s = mc_len - LEN_W'(1);
          end else begin
            state_s  = ST_IDLE;
          end
        end
        ST_MC_BUSY: begin
          if (mc_cnt_r <= LEN_W'(1)) begin
            state_s  = ST_IDLE;
            mc_cnt_s = {LEN_W{1'b0}};
          end else begin
            mc_cnt_s = mc_cnt_r - LEN_W'(1);
          end
        end
        ST_FLUSH: begin
          if (fl_cnt_r <= 4'd1) begin
            state_s  = ST_IDLE;
            flush_s  = 1'b0;
            fl_cnt_s = 4'd0;
          end else begin
            fl_cnt_s = fl_cnt_r - 4'd1;
          end
        end
        default: begin
          state_s  = ST_IDLE;
          flush_s  = 1'b0;
          mc_cnt_s = {LEN_W{1'b0}};
          fl_cnt_s = 4'd0;
        end
      endcase
    end
  end

  // FSM state, counters and redirect registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      mc_cnt_r <= {LEN_W{1'b0}};
      fl_cnt_r <= 4'd0;
      flush_r  <= 1'b0;
      new_pc_r <= {PC_W{1'b0}};
    end else begin
      state_r  <= state_s;
      mc_cnt_r <= mc_cnt_s;
      fl_cnt_r <= fl_cnt_s;
      flush_r  <= flush_s;
      new_pc_r <= new_pc_s;
    end
  end

  assign stall      = stall_s;
  assign flush      = flush_r & ~rst;
  assign new_pc     = new_pc_r;
  assign ctrl_state = state_r;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_r;
  logic [31:0] perf_flush_r;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_r <= 32'd0;
      perf_flush_r <= 32'd0;
    end else begin
      if (|stall_s) perf_stall_r <= perf_stall_r + 32'd1;
      else          perf_stall_r <= perf_stall_r;
      if (excp_valid) perf_flush_r <= perf_flush_r + 32'd1;
      else            perf_flush_r <= perf_flush_r;
    end
  end

  assign perf_stall_cnt = perf_stall_r;
  assign perf_flush_cnt = perf_flush_r;
`else
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table plus randomized cycles
// compared against a remaining-cycles reference model.
`timescale 1ns/1ps
module tb_pipe_ctrl;
  localparam int STAGES = 6, PC_W = 32, LEN_W = 6, FLUSH_CYCLES = 1;
  localparam logic [5:0] ID_M = 6'b000111;
  localparam logic [5:0] EX_M = 6'b001111;

  logic clk = 1'b0;
  logic rst, stallreq_id, stallreq_load, stallreq_ex, mc_start, excp_valid;
  logic [LEN_W-1:0] mc_len;
  logic [PC_W-1:0] excp_pc, new_pc;
  logic [STAGES-1:0] stall;
  logic flush;
  logic [1:0] ctrl_state;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  pipe_ctrl #(.STAGES(STAGES), .PC_W(PC_W), .LEN_W(LEN_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_load(stallreq_load),
    .stallreq_ex(stallreq_ex), .mc_start(mc_start), .mc_len(mc_len),
    .excp_valid(excp_valid), .excp_pc(excp_pc), .stall(stall), .flush(flush),
    .new_pc(new_pc), .ctrl_state(ctrl_state),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          tab;
    logic        rst, id, load, ex, mcs;
    logic [5:0]  len;
    logic        exv;
    logic [31:0] epc;
    logic [5:0]  e_stall;
    logic [1:0]  e_state;
    logic        e_flush;
    logic [31:0] e_pc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles of multi-cycle hold / flush still to come, plus redirect PC.
  int          m_mc_left, m_fl_left;
  logic [31:0] m_pc, m_pstall, m_pflush;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, id, ld, ex, mcs, input logic [5:0] len,
                              input logic exv, input logic [31:0] epc,
                              input logic [5:0] es, input logic [1:0] st,
                              input logic fl, input logic [31:0] pc);
    vec_t v;
    v.tab = 1'b1; v.rst = r; v.id = id; v.load = ld; v.ex = ex; v.mcs = mcs; v.len = len;
    v.exv = exv; v.epc = epc; v.e_stall = es; v.e_state = st; v.e_flush = fl; v.e_pc = pc;
    return v;
  endfunction

  function automatic logic [5:0] model_stall();
    if (rst)                                 return 6'd0;
    if (m_fl_left > 0)                       return 6'd0;
    if (m_mc_left > 0)                       return EX_M;
    if (stallreq_ex || (mc_start && mc_len != 6'd0)) return EX_M;
    if (stallreq_load || stallreq_id)        return ID_M;
    return 6'd0;
  endfunction

  task automatic step(input vec_t v);
    logic [5:0] es;
    logic [1:0] est;
    @(negedge clk);
    rst = v.rst; stallreq_id = v.id; stallreq_load = v.load; stallreq_ex = v.ex;
    mc_start = v.mcs; mc_len = v.len; excp_valid = v.exv; excp_pc = v.epc;
    #1;
    es  = model_stall();
    est = (m_fl_left > 0) ? 2'd2 : ((m_mc_left > 0) ? 2'd1 : 2'd0);
    chk("stall", stall, es);
    chk("ctrl_state", ctrl_state, est);
    chk("flush", flush, (!rst && m_fl_left > 0));
    chk("new_pc", new_pc, m_pc);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall", perf_stall_cnt, m_pstall);
    chk("perf_flush", perf_flush_cnt, m_pflush);
`else
    chk("perf_stall", perf_stall_cnt, 32'd0);
    chk("perf_flush", perf_flush_cnt, 32'd0);
`endif
    if (v.tab) begin
      chk("tab_stall", stall, v.e_stall);
      chk("tab_state", ctrl_state, v.e_state);
      chk("tab_flush", flush, v.e_flush);
      chk("tab_new_pc", new_pc, v.e_pc);
    end
    @(posedge clk);
    if (v.rst) begin
      m_mc_left = 0; m_fl_left = 0; m_pc = 32'd0; m_pstall = 32'd0; m_pflush = 32'd0;
    end else begin
      if (es != 6'd0) m_pstall = m_pstall + 32'd1;
      if (v.exv) begin
        m_pflush = m_pflush + 32'd1;
        m_fl_left = FLUSH_CYCLES; m_pc = v.epc; m_mc_left = 0;
      end else if (m_fl_left > 0) m_fl_left--;
      else if (m_mc_left > 0)     m_mc_left--;
      else if (v.mcs && v.len >= 6'd2) m_mc_left = int'(v.len) - 1;
    end
  endtask

  initial begin
    vec_t tbl[$];
    vec_t rv;
    rst = 1'b1; stallreq_id = 1'b0; stallreq_load = 1'b0; stallreq_ex = 1'b0;
    mc_start = 1'b0; mc_len = 6'd0; excp_valid = 1'b0; excp_pc = 32'd0;
    repeat (2) @(posedge clk);
    m_mc_left = 0; m_fl_left = 0; m_pc = 32'd0; m_pstall = 32'd0; m_pflush = 32'd0;

    //          rst id ld ex mcs len  exv epc           stall st fl pc
    tbl.push_back(mk(1, 0, 0, 1, 0, 6'd0, 0, 32'h0,      6'd0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 6'd0, 0, 32'h0,      ID_M, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      6'd0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 6'd0, 0, 32'h0,      ID_M, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 6'd0, 0, 32'h0,      EX_M, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 6'd0, 0, 32'h0,      6'd0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 6'd1, 0, 32'h0,      EX_M, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      6'd0, 0, 0, 32'h0));
    // mc_len=5: five EX-level cycles, a second start mid-way is ignored
    tbl.push_back(mk(0, 0, 0, 0, 1, 6'd5, 0, 32'h0,      EX_M, 0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 6'd0, 0, 32'h0,      EX_M, 1, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      EX_M, 1, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 6'd3, 0, 32'h0,      EX_M, 1, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      EX_M, 1, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      6'd0, 0, 0, 32'h0));
    // exception and mc_start together: flush wins
    tbl.push_back(mk(0, 0, 0, 0, 1, 6'd5, 1, 32'h1000,   EX_M, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      6'd0, 2, 1, 32'h1000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      6'd0, 0, 0, 32'h1000));
    // exception on third cycle of a 5-cycle op
    tbl.push_back(mk(0, 0, 0, 0, 1, 6'd5, 0, 32'h0,      EX_M, 0, 0, 32'h1000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      EX_M, 1, 0, 32'h1000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 1, 32'hBFC0,   EX_M, 1, 0, 32'h1000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      6'd0, 2, 1, 32'hBFC0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      6'd0, 0, 0, 32'hBFC0));
    // exception during flush reloads the target and restarts the count
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 1, 32'h2000,   6'd0, 0, 0, 32'hBFC0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 1, 32'h3000,   6'd0, 2, 1, 32'h2000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      6'd0, 2, 1, 32'h3000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      6'd0, 0, 0, 32'h3000));
    // reset in the middle of a multi-cycle op
    tbl.push_back(mk(0, 0, 0, 0, 1, 6'd4, 0, 32'h0,      EX_M, 0, 0, 32'h3000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      EX_M, 1, 0, 32'h3000));
    tbl.push_back(mk(1, 0, 0, 1, 0, 6'd0, 0, 32'h0,      6'd0, 1, 0, 32'h3000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      6'd0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 6'd0, 0, 32'h0,      ID_M, 0, 0, 32'h0));
    // counter scenario: reset, 5-cycle op, one exception
    tbl.push_back(mk(1, 0, 0, 0, 0, 6'd0, 0, 32'h0,      6'd0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 6'd5, 0, 32'h0,      EX_M, 0, 0, 32'h0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,    EX_M, 1, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 1, 32'hBFC0,   6'd0, 0, 0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      6'd0, 2, 1, 32'hBFC0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 6'd0, 0, 32'h0,      6'd0, 0, 0, 32'hBFC0));

    foreach (tbl[i]) step(tbl[i]);

    @(negedge clk);
    #1;
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_stall_total", perf_stall_cnt, 32'd5);
    chk("perf_flush_total", perf_flush_cnt, 32'd1);
`else
    chk("perf_stall_total", perf_stall_cnt, 32'd0);
    chk("perf_flush_total", perf_flush_cnt, 32'd0);
`endif

    for (int n = 0; n < 3000; n++) begin
      rv.tab  = 1'b0;
      rv.rst  = ($urandom_range(0, 63) == 0);
      rv.id   = ($urandom_range(0, 3) == 0);
      rv.load = ($urandom_range(0, 3) == 0);
      rv.ex   = ($urandom_range(0, 5) == 0);
      rv.mcs  = ($urandom_range(0, 7) == 0);
      rv.len  = 6'($urandom_range(0, 9));
      rv.exv  = ($urandom_range(0, 15) == 0);
      rv.epc  = $urandom;
      rv.e_stall = 6'd0; rv.e_state = 2'd0; rv.e_flush = 1'b0; rv.e_pc = 32'd0;
      step(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
